// File: rtl/cbx_io_tile_cfg.sv
// cbx_io_tile_cfg: perimeter connection block plus I/O tile. Channel pass-through, per-pad
// output select, and a counted serial config chain that commits into a shadow register.
`default_nettype none

module cbx_io_tile_cfg #(
  parameter int CHAN_W = 30,
  parameter int NUM_IO = 4,
  parameter int SEL_W  = 6
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              ccff_head,
  input  logic              ccff_en,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [CHAN_W-1:0] chanx_right_in,
  input  logic [NUM_IO-1:0] gfpga_pad_io_soc_in,
  input  logic              isol_n,
  output logic [CHAN_W-1:0] chanx_left_out,
  output logic [CHAN_W-1:0] chanx_right_out,
  output logic [NUM_IO-1:0] grid_inpad,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_out,
  output logic [NUM_IO-1:0] gfpga_pad_io_soc_dir,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_valid
);

  localparam int FLD_W   = SEL_W + 1;
  localparam int CFG_LEN = NUM_IO * FLD_W;
  localparam int CNT_W   = (CFG_LEN > 1) ? $clog2(CFG_LEN) : 1;
  localparam int SRC_W   = 1 << SEL_W;

  typedef enum logic [1:0] {
    ST_UNCONF = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CFG_LEN-1:0] sr_q, sr_d, sr_shift;
  logic [CFG_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               done_q;
  logic               commit;
  logic [NUM_IO-1:0]  pad_out_q, pad_dir_q;
  logic [NUM_IO-1:0]  out_d, dir_d;
  logic [SRC_W-1:0]   src;

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  always_comb begin
    sr_shift = {sr_q[CFG_LEN-2:0], ccff_head};
    commit   = ccff_en && (cnt_q == CNT_W'(CFG_LEN - 1));
    sr_d     = ccff_en ? sr_shift : sr_q;
    shadow_d = commit ? sr_shift : shadow_q;
    cnt_d    = cnt_q;
    if (ccff_en) begin
      cnt_d = commit ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    case (state_q)
      ST_UNCONF: if (ccff_en) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (commit) begin
          state_d = ST_ACTIVE;
          valid_d = 1'b1;
        end
      end
      ST_ACTIVE: if (ccff_en) state_d = ST_SHIFT;
      default:   state_d = ST_UNCONF;
    endcase
  end

  // Zero-padded to 2^SEL_W so selects past the real tracks read 0 without a range check.
  always_comb begin
    src                 = '0;
    src[2*CHAN_W-1:0]   = {chanx_right_in, chanx_left_in};
  end

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    logic [SEL_W-1:0] sel;
    logic             dir;
    assign sel      = shadow_q[i*FLD_W +: SEL_W];
    assign dir      = shadow_q[i*FLD_W + SEL_W];
    assign out_d[i] = (isol_n && valid_q) ? src[sel] : 1'b0;
    assign dir_d[i] = (isol_n && valid_q) ? dir : 1'b1;
  end

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q   <= ST_UNCONF;
      sr_q      <= '0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      pad_out_q <= '0;
      pad_dir_q <= '1;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      done_q    <= commit;
      pad_out_q <= out_d;
      pad_dir_q <= dir_d;
    end
  end

  assign gfpga_pad_io_soc_out = pad_out_q;
  assign gfpga_pad_io_soc_dir = pad_dir_q;
  // Reset is asynchronous, so the fabric input is forced low directly while it is held.
  assign grid_inpad           = gfpga_pad_io_soc_in & pad_dir_q & {NUM_IO{prog_reset}};
  assign ccff_tail            = sr_q[CFG_LEN-1];
  assign cfg_done             = done_q;
  assign cfg_valid            = valid_q;

endmodule

`default_nettype wire
